// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: queues {mode, count} commands in a small FIFO and plays
// each one as a stepped LED pattern, with a blank gap between commands.
module led_seq_ctrl #(
  parameter int TICK_DIV   = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] inSwitch,
  input  logic [3:0] repeatCnt,
  input  logic       valid,
  output logic       ready,
  output logic       busy,
  output logic       outBit1,
  output logic       outBit2,
  output logic       outBit3,
  output logic       outBit4
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP
  } SeqState;

  SeqState state, stateNext;

  logic [5:0]    fifoMem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   fifoCount;
  logic          fifoEmpty, push, pop;
  logic [1:0]    headMode;
  logic [4:0]    headCount;

  logic [1:0]    mode, modeNext;
  logic [4:0]    stepCount, countNext;
  logic [4:0]    stepIdx, stepNext, stepInc;
  logic [TW-1:0] tickCnt, tickNext;
  logic          tickDone;
  logic [3:0]    leds, ledsNext;

  function automatic logic [3:0] patternFor(input logic [1:0] m, input logic [4:0] k);
    case (m)
      2'b00:   patternFor = k[0] ? 4'b0000 : 4'b1111;
      2'b01:   patternFor = 4'b0001 << k[1:0];
      2'b10:   patternFor = 4'b1000 >> k[1:0];
      default: patternFor = k[3:0];
    endcase
  endfunction

  assign ready     = (fifoCount != FIFO_FULL);
  assign fifoEmpty = (fifoCount == '0);
  assign push      = valid && ready;
  assign pop       = (state == LOAD);
  assign headMode  = fifoMem[rdPtr][5:4];
  // A stored count of zero stands for a full 16-step run
  assign headCount = (fifoMem[rdPtr][3:0] == 4'd0) ? 5'd16 : {1'b0, fifoMem[rdPtr][3:0]};

  always_ff @(posedge clk) begin
    if (rstn && push) begin
      fifoMem[wrPtr] <= {inSwitch, repeatCnt};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      mode      <= '0;
      stepCount <= '0;
      stepIdx   <= '0;
      tickCnt   <= '0;
      leds      <= '0;
    end else begin
      state     <= stateNext;
      mode      <= modeNext;
      stepCount <= countNext;
      stepIdx   <= stepNext;
      tickCnt   <= tickNext;
      leds      <= ledsNext;
    end
  end

  assign tickDone = (tickCnt == TICK_LAST);
  assign stepInc  = stepIdx + 5'd1;

  always_comb begin
    stateNext = state;
    modeNext  = mode;
    countNext = stepCount;
    stepNext  = stepIdx;
    tickNext  = tickCnt;
    ledsNext  = leds;
    case (state)
      IDLE: begin
        ledsNext = 4'b0000;
        if (!fifoEmpty) stateNext = LOAD;
      end
      LOAD: begin
        modeNext  = headMode;
        countNext = headCount;
        stepNext  = '0;
        tickNext  = '0;
        ledsNext  = patternFor(headMode, 5'd0);
        stateNext = PLAY;
      end
      PLAY: begin
        if (tickDone) begin
          tickNext = '0;
          stepNext = stepInc;
          if (stepInc == stepCount) begin
            ledsNext  = 4'b0000;
            stateNext = GAP;
          end else begin
            ledsNext = patternFor(mode, stepInc);
          end
        end else begin
          tickNext = tickCnt + 1'b1;
        end
      end
      GAP: begin
        if (tickDone) begin
          tickNext  = '0;
          stateNext = fifoEmpty ? IDLE : LOAD;
        end else begin
          tickNext = tickCnt + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign {outBit4, outBit3, outBit2, outBit1} = leds;

endmodule
